// File: rtl/systolic_input_feeder.sv
// Buffers acquisition samples and presents one word per SLOT_CYCLES-cycle slot to the PE chain; optional SYSTOLIC_FEEDER_UNDERRUN_HOLD_EN.
// A word written into an empty FIFO while idle appears one cycle after its write; sample_ready drops only while the FIFO is full.
module systolic_feeder_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk30x,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [AW:0]   level,
  output logic          full
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head_dat = mem[rd_ptr];
  assign full     = (level == (AW+1)'(DEPTH));

  always_ff @(posedge clk30x) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk30x or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + (AW+1)'(1);
      else if (!push && pop) level <= level - (AW+1)'(1);
    end
  end
endmodule

module systolic_input_feeder #(
  parameter int WORDLENGTH  = 16,
  parameter int SLOT_CYCLES = 30,
  parameter int FIFO_DEPTH  = 8,
  parameter int FIFO_AW     = 3
) (
  input  logic                  clk30x,
  input  logic                  reset,
  input  logic [WORDLENGTH-1:0] sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  input  logic                  run_en,
  output logic [WORDLENGTH-1:0] inputword,
  output logic                  word_strobe,
  output logic [2:0]            word_index,
  output logic [FIFO_AW:0]      fifo_level,
  output logic                  underrun
);
  localparam int CW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SLOT_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state;
  logic [CW-1:0]         counter;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [WORDLENGTH-1:0] head_dat;

  assign sample_ready = !fifo_full;
  assign push         = sample_valid && sample_ready;
  assign fifo_empty   = (fifo_level == '0);
  assign word_strobe  = (state == RUN) && (counter == '0);

  // Pops happen only at a slot start from idle or at a slot boundary while still enabled.
  always_comb begin
    pop = 1'b0;
    if (run_en && !fifo_empty)
      pop = (state == IDLE) || (counter == LAST);
  end

  systolic_feeder_fifo #(
    .W     (WORDLENGTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk30x   (clk30x),
    .reset    (reset),
    .push     (push),
    .push_dat (sample_in),
    .pop      (pop),
    .head_dat (head_dat),
    .level    (fifo_level),
    .full     (fifo_full)
  );

  always_ff @(posedge clk30x or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      counter    <= '0;
      inputword  <= '0;
      word_index <= '0;
      underrun   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run_en && !fifo_empty) begin
            inputword  <= head_dat;
            counter    <= '0;
            word_index <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (counter != LAST) begin
            counter <= counter + CW'(1);
          end else begin
            counter <= '0;
            if (!run_en) begin
              state      <= IDLE;
              word_index <= '0;
            end else begin
              word_index <= word_index + 3'd1;
              if (!fifo_empty) begin
                inputword <= head_dat;
              end else begin
                // Empty slot still advances so every PE stays on the same slot grid.
                underrun <= 1'b1;
`ifdef SYSTOLIC_FEEDER_UNDERRUN_HOLD_EN
                inputword <= inputword;
`else
                inputword <= '0;
`endif
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/systolic_input_feeder.md
Name: systolic_input_feeder

Overview:
- Upstream stage of the systolic PE chain.
- Accepts non-uniform samples from the acquisition side through a valid/ready handshake and buffers them in a small FIFO.
- Presents one sample on `inputword`, held stable for exactly SLOT_CYCLES clk30x cycles, together with a slot strobe and a 3-bit word index.
- Keeps every PE's sequential multiplier and coefficient selection aligned to the same word slot.

Parameters:
- WORDLENGTH, 16: sample width.
- SLOT_CYCLES, 30: clk30x cycles per word slot; must be ≥ 2.
- FIFO_DEPTH, 8: sample FIFO entries; power of two.
- FIFO_AW, 3: log2(FIFO_DEPTH).

Ports:
- clk30x  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- sample_in  in  WORDLENGTH  sample from acquisition.
- sample_valid  in  1  sample_in valid.
- sample_ready  out  1  FIFO can accept; a write occurs when valid && ready.
- run_en  in  1  permits slots to start or continue.
- inputword  out  WORDLENGTH  word driven to the PE chain; registered.
- word_strobe  out  1  high during the first cycle of each slot.
- word_index  out  3  slot number within the 8-word window; wraps 7→0.
- fifo_level  out  FIFO_AW+1  current FIFO occupancy, 0..FIFO_DEPTH.
- underrun  out  1  sticky: a slot boundary found the FIFO empty.

Behaviour:
- Reset (asynchronous, immediate):
  - FIFO empty; fifo_level=0, sample_ready=1.
  - inputword=0, word_strobe=0, word_index=0, underrun=0.
  - Slot counter=0; state=IDLE.
  - Reset mid-slot discards buffered samples and the current slot with no partial output.
- FIFO:
  - sample_ready = (fifo_level != FIFO_DEPTH); there is no bypass when full.
  - Simultaneous push and pop leaves fifo_level unchanged. Pointers wrap modulo FIFO_DEPTH.
  - A push is visible to a pop no earlier than the cycle after the write; there is no write-to-read bypass.
- State IDLE:
  - inputword holds its last value; word_strobe=0.
  - If run_en=1 and fifo_level≥1 at an edge: pop the head into inputword, counter←0, word_index←0, go to RUN.
- State RUN:
  - word_strobe = (counter==0), combinational from the registered counter. It is therefore high in the first cycle inputword shows a new word.
  - counter increments each cycle. On the edge where counter==SLOT_CYCLES-1 (slot end):
    - If run_en=0: go to IDLE, counter←0, word_index←0, no pop, inputword held.
    - Else if FIFO non-empty: pop into inputword, counter←0, word_index←word_index+1 (mod 8).
    - Else (underrun): inputword←0, underrun←1, counter←0, word_index←word_index+1. Slot timing is preserved so the PEs stay aligned.
  - run_en changes mid-slot have no effect until slot end.
- Latency:
  - Sample written at edge N into an empty FIFO while IDLE with run_en=1 appears on inputword after edge N+1, with word_strobe high that cycle.
  - Slot period is exactly SLOT_CYCLES cycles; word_strobe is a 1-cycle pulse every SLOT_CYCLES cycles in RUN.
- underrun clears only on reset.

Optional Feature:
- Macro SYSTOLIC_FEEDER_UNDERRUN_HOLD_EN.
- Defined: on underrun, inputword keeps the previous slot's word instead of loading 0. underrun is still set and word_index still advances.
- Undefined: zero-fill on underrun as described in Behaviour.

Test Plan:
- Reset check: assert reset asynchronously mid-cycle → inputword=0, word_index=0, fifo_level=0, sample_ready=1, underrun=0 immediately, without waiting for a clock edge.
- Startup: run_en=1, push 0x1234 → one cycle after the write, inputword=0x1234, word_strobe=1 for 1 cycle, word_index=0; word held 30 cycles.
- Streaming: push 10 words 0x0001..0x000A back-to-back with run_en=1 → strobes every 30 cycles; word_index runs 0..7,0,1; each word held exactly 30 cycles.
- Full: run_en=0, push 9 words → sample_ready=0 after 8 writes, fifo_level=8, 9th word not accepted until a pop occurs.
- Underrun: push 2 words, run_en=1 → third slot has inputword=0 (or the second word with SYSTOLIC_FEEDER_UNDERRUN_HOLD_EN), underrun=1, word_index=2.
- Stop: drop run_en at cycle 10 of slot 3 → slot completes at cycle 29, state IDLE, word_index=0, no pop; raising run_en again restarts at word_index=0.
